// File: rtl/matmul_tile_feeder_pkg.sv
// rtl/matmul_tile_feeder_pkg.sv - shared types and constants for the matmul tile feeder
// Purpose: FSM state encoding, tile size and the beat record carried through the output FIFO.
package matmul_pkg;

  localparam int DATA_W = 64;
  localparam int S_W    = 3;
  localparam int S      = 1 << S_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              tile_last;
    logic              job_last;
  } beat_t;

endpackage

// File: rtl/matmul_feed_fifo.sv
// rtl/matmul_feed_fifo.sv - 2-entry synchronous FIFO of feeder beats with flush
// Ports: clk/rst (async active-high), i_push/i_data write side, i_pop read side,
//        i_flush empties the FIFO, o_head is the oldest entry, o_count holds 0..2.
module matmul_feed_fifo
  import matmul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  beat_t      i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output beat_t      o_head,
  output logic [1:0] o_count
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/matmul_tile_feeder.sv
// rtl/matmul_tile_feeder.sv - streams A/B beat pairs in tile order from two sync-read memories
// Ports: start/abort/N_in/a_base/b_base job control; mem_rd_en/a_addr/b_addr/a_rdata/b_rdata
//        memory side; A_out/B_out/out_valid/out_ready/tile_last/job_last beat stream;
//        busy/done/err status.
module matmul_tile_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int S_WIDTH     = S_W,
  parameter int N_MAX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_MAX_WIDTH-1:0] N_in,
  input  logic [ADDR_WIDTH-1:0]  a_base,
  input  logic [ADDR_WIDTH-1:0]  b_base,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  a_addr,
  output logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0]  a_rdata,
  input  logic [DATA_WIDTH-1:0]  b_rdata,
  output logic [DATA_WIDTH-1:0]  A_out,
  output logic [DATA_WIDTH-1:0]  B_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   tile_last,
  output logic                   job_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int S_VAL = 1 << S_WIDTH;

  state_t                   r_state, w_state_nxt;
  logic [N_MAX_WIDTH-1:0]   r_n_val, r_i, r_j, r_n, w_tiles_m1;
  logic [S_WIDTH-1:0]       r_ii;
  // a: tile base (i*S*N), row base (+n), current (+ii*N). b: column base (j*S), row (+n*N), current (+ii).
  logic [ADDR_WIDTH-1:0]    r_a_tile, r_a_row, r_a_addr;
  logic [ADDR_WIDTH-1:0]    r_b_base, r_b_col, r_b_row, r_b_addr;
  logic [ADDR_WIDTH-1:0]    w_n_a, w_sn_a;
  logic [2*N_MAX_WIDTH-1:0] w_n_sq;
  logic                     w_legal, w_start_ok, w_rd_en, w_pop, w_flush;
  logic                     w_last_ii, w_last_n, w_last_j, w_last_i;
  logic [2:0]               w_occ;
  logic                     r_inflight, r_if_tile, r_if_job, r_done, r_err;
  logic [1:0]               w_count;
  beat_t                    w_head, w_push_beat;

  // Squaring only feeds the start-time legality check, never the address path.
  assign w_n_sq  = {{N_MAX_WIDTH{1'b0}}, N_in} * {{N_MAX_WIDTH{1'b0}}, N_in};
  assign w_legal = (N_in >= N_MAX_WIDTH'(S_VAL)) && (N_in[S_WIDTH-1:0] == '0)
                && ((w_n_sq >> ADDR_WIDTH) == '0);

  assign w_tiles_m1 = (r_n_val >> S_WIDTH) - N_MAX_WIDTH'(1);
  assign w_n_a      = r_n_val[ADDR_WIDTH-1:0];
  assign w_sn_a     = w_n_a << S_WIDTH;
  assign w_last_ii  = &r_ii;
  assign w_last_n   = (r_n == r_n_val - N_MAX_WIDTH'(1));
  assign w_last_j   = (r_j == w_tiles_m1);
  assign w_last_i   = (r_i == w_tiles_m1);

  assign w_pop   = (w_count != 2'd0) && out_ready;
  assign w_flush = abort && (r_state != ST_IDLE);
  // Occupancy after this cycle's pop, counting the read whose data arrives next cycle.
  assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort && w_legal) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_occ < 3'd2) begin
          w_rd_en = 1'b1;
          if (w_last_ii && w_last_n && w_last_j && w_last_i) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort || (w_pop && w_head.job_last)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_val  <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_n      <= '0;
      r_ii     <= '0;
      r_a_tile <= '0;
      r_a_row  <= '0;
      r_a_addr <= '0;
      r_b_base <= '0;
      r_b_col  <= '0;
      r_b_row  <= '0;
      r_b_addr <= '0;
    end else if (w_start_ok) begin
      r_n_val  <= N_in;
      r_i      <= '0;
      r_j      <= '0;
      r_n      <= '0;
      r_ii     <= '0;
      r_a_tile <= a_base;
      r_a_row  <= a_base;
      r_a_addr <= a_base;
      r_b_base <= b_base;
      r_b_col  <= b_base;
      r_b_row  <= b_base;
      r_b_addr <= b_base;
    end else if (w_rd_en) begin
      if (!w_last_ii) begin
        r_ii     <= r_ii + S_WIDTH'(1);
        r_a_addr <= r_a_addr + w_n_a;
        r_b_addr <= r_b_addr + ADDR_WIDTH'(1);
      end else begin
        r_ii <= '0;
        if (!w_last_n) begin
          r_n      <= r_n + N_MAX_WIDTH'(1);
          r_a_row  <= r_a_row + ADDR_WIDTH'(1);
          r_a_addr <= r_a_row + ADDR_WIDTH'(1);
          r_b_row  <= r_b_row + w_n_a;
          r_b_addr <= r_b_row + w_n_a;
        end else begin
          r_n <= '0;
          if (!w_last_j) begin
            r_j      <= r_j + N_MAX_WIDTH'(1);
            r_a_row  <= r_a_tile;
            r_a_addr <= r_a_tile;
            r_b_col  <= r_b_col + ADDR_WIDTH'(S_VAL);
            r_b_row  <= r_b_col + ADDR_WIDTH'(S_VAL);
            r_b_addr <= r_b_col + ADDR_WIDTH'(S_VAL);
          end else begin
            r_j      <= '0;
            r_i      <= r_i + N_MAX_WIDTH'(1);
            r_a_tile <= r_a_tile + w_sn_a;
            r_a_row  <= r_a_tile + w_sn_a;
            r_a_addr <= r_a_tile + w_sn_a;
            r_b_col  <= r_b_base;
            r_b_row  <= r_b_base;
            r_b_addr <= r_b_base;
          end
        end
      end
    end
  end

  // Tags travel with the read; w_rd_en is never high during abort, so late data is never pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_if_tile  <= 1'b0;
      r_if_job   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_if_tile <= w_last_ii && w_last_n;
        r_if_job  <= w_last_ii && w_last_n && w_last_j && w_last_i;
      end
      r_done <= (r_state == ST_DRAIN) && !abort && w_pop && w_head.job_last;
      r_err  <= (r_state == ST_IDLE) && start && !abort && !w_legal;
    end
  end

  assign w_push_beat = '{a: a_rdata, b: b_rdata, tile_last: r_if_tile, job_last: r_if_job};

  matmul_feed_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_rd_en = w_rd_en;
  assign a_addr    = r_a_addr;
  assign b_addr    = r_b_addr;
  assign A_out     = w_head.a;
  assign B_out     = w_head.b;
  assign tile_last = w_head.tile_last;
  assign job_last  = w_head.job_last;
  assign out_valid = (w_count != 2'd0);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_matmul_tile_feeder.sv
// tb/tb_matmul_tile_feeder.sv - self-checking bench for matmul_tile_feeder
module tb_matmul_tile_feeder;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [31:0] N_in;
  logic [15:0] a_base, b_base, a_addr, b_addr;
  logic [63:0] a_rdata = '0, b_rdata = '0, A_out, B_out;
  logic        mem_rd_en, out_valid, tile_last, job_last, busy, done, err;

  logic [129:0] exp_q[$];
  int nchk = 0;
  int nfail = 0;
  int beats, cycles;
  bit ended;

  always #5 clk = ~clk;

  matmul_tile_feeder dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .N_in(N_in),
    .a_base(a_base), .b_base(b_base), .mem_rd_en(mem_rd_en), .a_addr(a_addr),
    .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata), .A_out(A_out),
    .B_out(B_out), .out_valid(out_valid), .out_ready(out_ready),
    .tile_last(tile_last), .job_last(job_last), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [63:0] fa(input logic [15:0] ad);
    return {16'hA5A5, ad, ~ad, ad ^ 16'h3C3C};
  endfunction

  function automatic logic [63:0] fb(input logic [15:0] ad);
    return {16'hB00B, ad, ad ^ 16'h5A5A, ~ad};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      a_rdata <= fa(a_addr);
      b_rdata <= fb(b_addr);
    end
  end

  task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, 132'({mem_rd_en, out_valid, tile_last, job_last, busy, done, err, a_addr, b_addr}), '0);
    chk({tag, "_data"}, 132'({A_out, B_out}), '0);
  endtask

  task automatic model(input int nn, input logic [15:0] ab, input logic [15:0] bb);
    int t;
    logic [15:0] aa, ba;
    logic tl, jl;
    t = nn / 8;
    for (int i = 0; i < t; i++)
      for (int j = 0; j < t; j++)
        for (int n = 0; n < nn; n++)
          for (int ii = 0; ii < 8; ii++) begin
            aa = 16'(int'(ab) + (i * 8 + ii) * nn + n);
            ba = 16'(int'(bb) + n * nn + j * 8 + ii);
            tl = (n == nn - 1) && (ii == 7);
            jl = tl && (i == t - 1) && (j == t - 1);
            exp_q.push_back({fa(aa), fb(ba), tl, jl});
          end
  endtask

  task automatic start_job(input int nn, input logic [15:0] ab, input logic [15:0] bb);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    N_in = 32'(nn);
    a_base = ab;
    b_base = bb;
    model(nn, ab, bb);
    @(negedge clk);
    start = 1'b0;
    chk("lat_busy", 132'(busy), 132'(1));
    chk("lat_rd", 132'(mem_rd_en), 132'(1));
    chk("lat_addr", 132'({a_addr, b_addr}), 132'({ab, bb}));
    @(negedge clk);
    chk("lat_valid2", 132'(out_valid), 132'(0));
    @(negedge clk);
    chk("lat_valid3", 132'(out_valid), 132'(1));
  endtask

  // mode 0: ready held high, 1: random, 2: toggling. *_at < 0 disables that event.
  task automatic run(input int mode, input int abort_at, input int restart_at, input int rst_at,
                     input int budget, output int nb, output int cyc, output bit fin_ok);
    logic [129:0] hold, e;
    bit stall, fin;
    stall = 0; fin = 0; nb = 0; cyc = 0; fin_ok = 0;
    hold = '0;
    while (!fin_ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = ~out_ready;
      if (start) begin
        start = 1'b0;
        N_in = 32'd16;
      end
      if (stall)
        chk("stable", 132'({out_valid, A_out, B_out, tile_last, job_last}), 132'({1'b1, hold}));
      chk("done", 132'(done), 132'(fin));
      if (fin) begin
        chk("busy_after_done", 132'(busy), 132'(0));
        fin_ok = 1;
      end else begin
        stall = out_valid && !out_ready;
        hold = {A_out, B_out, tile_last, job_last};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 132'(nb), 132'(-1));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", nb), 132'({A_out, B_out, tile_last, job_last}), 132'(e));
          end
          nb++;
          if (job_last) fin = 1;
          if (nb == restart_at) begin
            start = 1'b1;
            N_in = 32'd8;
          end
          if (nb == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_valid", 132'(out_valid), 132'(0));
            chk("abort_busy", 132'(busy), 132'(0));
            repeat (4) begin
              @(negedge clk);
              chk("abort_quiet", 132'({out_valid, mem_rd_en, done, busy}), 132'(0));
            end
            exp_q.delete();
            fin_ok = 1;
          end
          if (nb == rst_at) begin
            rst = 1'b1;
            #1;
            chk_outs_zero("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            fin_ok = 1;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    N_in = '0; a_base = '0; b_base = '0;
    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_outs_zero("post_reset");

    // N=16, ready high: 512 beats back to back
    start_job(16, 16'h0000, 16'h0000);
    run(0, -1, -1, -1, 3000, beats, cycles, ended);
    chk("s1_end", 132'(ended), 132'(1));
    chk("s1_beats", 132'(beats), 132'(512));
    chk("s1_cycles", 132'(cycles), 132'(513));
    chk("s1_q", 132'(exp_q.size()), 132'(0));

    // same job with random backpressure
    start_job(16, 16'h0000, 16'h0000);
    run(1, -1, -1, -1, 6000, beats, cycles, ended);
    chk("s2_end", 132'(ended), 132'(1));
    chk("s2_beats", 132'(beats), 132'(512));
    chk("s2_q", 132'(exp_q.size()), 132'(0));

    // addresses wrapping past the top of the address space
    start_job(8, 16'hFFF0, 16'hFFC0);
    run(0, -1, -1, -1, 500, beats, cycles, ended);
    chk("wrap_beats", 132'(beats), 132'(64));
    chk("wrap_cycles", 132'(cycles), 132'(65));

    // illegal N: err pulses once, no reads, never busy
    @(negedge clk);
    start = 1'b1;
    N_in = 32'd12;
    @(negedge clk);
    start = 1'b0;
    chk("ill_err", 132'({err, busy, mem_rd_en}), 132'(3'b100));
    repeat (4) begin
      @(negedge clk);
      chk("ill_quiet", 132'({err, busy, mem_rd_en, out_valid}), 132'(0));
    end

    // N=8: single tile
    start_job(8, 16'h0100, 16'h0200);
    run(0, -1, -1, -1, 500, beats, cycles, ended);
    chk("n8_beats", 132'(beats), 132'(64));
    chk("n8_q", 132'(exp_q.size()), 132'(0));

    // abort at beat 200 with toggling ready, then a clean N=8 job
    start_job(16, 16'h0000, 16'h0000);
    run(2, 200, -1, -1, 3000, beats, cycles, ended);
    chk("abort_end", 132'(ended), 132'(1));
    chk("abort_beats", 132'(beats), 132'(200));
    start_job(8, 16'h0000, 16'h0000);
    run(0, -1, -1, -1, 500, beats, cycles, ended);
    chk("post_abort_beats", 132'(beats), 132'(64));

    // start re-pulsed mid-job with N_in=8 is ignored
    start_job(16, 16'h0040, 16'h0080);
    run(0, -1, 50, -1, 3000, beats, cycles, ended);
    chk("restart_beats", 132'(beats), 132'(512));
    chk("restart_q", 132'(exp_q.size()), 132'(0));

    // reset mid-job, then a full N=16 job
    start_job(16, 16'h0000, 16'h0000);
    run(1, -1, -1, 100, 3000, beats, cycles, ended);
    chk("rst_beats", 132'(beats), 132'(100));
    start_job(16, 16'h0000, 16'h0000);
    run(0, -1, -1, -1, 3000, beats, cycles, ended);
    chk("post_rst_beats", 132'(beats), 132'(512));
    chk("post_rst_cycles", 132'(cycles), 132'(513));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
